booth_mul_ctrl: RTL and testbench

BOOTH_MUL_CTRL -- requirements
Module: booth_mul_ctrl

---
 rtl/booth_pkg.sv | 32 +++
 rtl/eight_bit_adder_subractor.sv | 26 ++
 rtl/booth_mul_ctrl.sv | 169 ++++++++++++++++
 tb/tb_booth_mul_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared widths, iteration count, FSM state encoding and the
//               true-sign helper for the radix-2 Booth multiplier.
// Revision    : 1.0  initial release
// ============================================================================
package booth_pkg;

  // Operand width and number of Booth iterations.
  localparam int C_OP_W  = 8;
  localparam int C_CNT_W = 4;
  localparam logic [C_CNT_W-1:0] C_ITERS = 4'd8;

  // Controller state encoding.
  typedef logic [1:0] state_t;
  localparam state_t C_ST_IDLE  = 2'd0;
  localparam state_t C_ST_ADD   = 2'd1;
  localparam state_t C_ST_SHIFT = 2'd2;
  localparam state_t C_ST_DONE  = 2'd3;

  // Sign of the exact 9-bit result of A + X (+cin).
  // When both addends share a sign and the 8-bit sum flips it, the sum has
  // overflowed and the real sign is that of the addends.
  function automatic logic booth_true_sign(input logic a7,
                                           input logic x7,
                                           input logic s7);
    booth_true_sign = ((a7 == x7) && (s7 != a7)) ? a7 : s7;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eight_bit_adder_subractor.sv
`default_nettype none
// ============================================================================
// Module      : eight_bit_adder_subractor
// Description : 8-bit adder/subtractor. cin=0 gives i0+i1, cin=1 gives
//               i0-i1 (i1 inverted and cin injected as the +1).
// Revision    : 1.0  initial release
// ============================================================================
module eight_bit_adder_subractor
  import booth_pkg::*;
(
  input  logic [C_OP_W-1:0] i0,
  input  logic [C_OP_W-1:0] i1,
  input  logic              cin,
  output logic [C_OP_W-1:0] sum
);

  logic [C_OP_W-1:0] w_x;

  // Conditionally invert the second operand, then add with carry-in.
  always_comb begin
    w_x = i1 ^ {C_OP_W{cin}};
    sum = i0 + w_x + {{(C_OP_W-1){1'b0}}, cin};
  end

endmodule
`default_nettype wire

// File: rtl/booth_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_ctrl
// Description : Sequential radix-2 Booth multiplier, 8x8 signed -> 16 signed.
//               IDLE -> (ADD -> SHIFT) x8 -> DONE -> IDLE.
//               Optional macro BOOTH_FAST_EN merges the add and the shift
//               into the ADD state so SHIFT is never visited.
// Revision    : 1.0  initial release
// ============================================================================
module booth_mul_ctrl
  import booth_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [C_OP_W-1:0]   multiplicand,
  input  logic [C_OP_W-1:0]   multiplier,
  output logic                busy,
  output logic                done,
  output logic [2*C_OP_W-1:0] product
);

  state_t               r_state;
  state_t               w_state_next;

  logic [C_OP_W-1:0]    r_a;
  logic [C_OP_W-1:0]    r_q;
  logic [C_OP_W-1:0]    r_m;
  logic                 r_q_1;
  logic [C_CNT_W-1:0]   r_count;
  logic [2*C_OP_W-1:0]  r_product;

`ifndef BOOTH_FAST_EN
  // Sign of the exact add result, kept from ADD so SHIFT can feed A[7]
  // correctly even when the 8-bit A has overflowed.
  logic                 r_sign;
`endif

  logic                 w_op_sub;
  logic                 w_op_add;
  logic                 w_cin;
  logic [C_OP_W-1:0]    w_sum;
  logic [C_OP_W-1:0]    w_a_next;
  logic                 w_sign_next;
  logic [C_OP_W-1:0]    w_a_pre;
  logic                 w_sign_pre;
  logic [C_OP_W-1:0]    w_a_sh;
  logic [C_OP_W-1:0]    w_q_sh;
  logic                 w_last;

  // The single arithmetic unit: A +/- M.
  eight_bit_adder_subractor u_addsub (
    .i0  (r_a),
    .i1  (r_m),
    .cin (w_cin),
    .sum (w_sum)
  );

  // Booth decode, operation select and the shifted {A,Q} candidate.
  always_comb begin
    w_op_sub    = (r_q[0] == 1'b1) && (r_q_1 == 1'b0);
    w_op_add    = (r_q[0] == 1'b0) && (r_q_1 == 1'b1);
    w_cin       = w_op_sub;
    w_a_next    = (w_op_sub || w_op_add) ? w_sum : r_a;
    w_sign_next = (w_op_sub || w_op_add)
                ? booth_true_sign(r_a[C_OP_W-1], r_m[C_OP_W-1] ^ w_cin,
                                  w_sum[C_OP_W-1])
                : r_a[C_OP_W-1];
`ifdef BOOTH_FAST_EN
    w_a_pre     = w_a_next;
    w_sign_pre  = w_sign_next;
`else
    w_a_pre     = r_a;
    w_sign_pre  = r_sign;
`endif
    w_a_sh      = {w_sign_pre, w_a_pre[C_OP_W-1:1]};
    w_q_sh      = {w_a_pre[0], r_q[C_OP_W-1:1]};
    w_last      = (r_count == 4'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_ST_IDLE:  w_state_next = start ? C_ST_ADD : C_ST_IDLE;
`ifdef BOOTH_FAST_EN
      C_ST_ADD:   w_state_next = w_last ? C_ST_DONE : C_ST_ADD;
      C_ST_SHIFT: w_state_next = C_ST_IDLE;
`else
      C_ST_ADD:   w_state_next = C_ST_SHIFT;
      C_ST_SHIFT: w_state_next = w_last ? C_ST_DONE : C_ST_ADD;
`endif
      C_ST_DONE:  w_state_next = C_ST_IDLE;
      default:    w_state_next = C_ST_IDLE;
    endcase
  end

  // Output decode: busy covers every non-IDLE state, done marks DONE.
  always_comb begin
    busy    = (r_state != C_ST_IDLE);
    done    = (r_state == C_ST_DONE);
    product = r_product;
  end

  // Datapath registers: operand capture, add, shift and product latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_q_1     <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
`ifndef BOOTH_FAST_EN
      r_sign    <= 1'b0;
`endif
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (start) begin
            r_a     <= '0;
            r_q     <= multiplier;
            r_q_1   <= 1'b0;
            r_m     <= multiplicand;
            r_count <= C_ITERS;
          end
        end
`ifdef BOOTH_FAST_EN
        C_ST_ADD: begin
          r_a     <= w_a_sh;
          r_q     <= w_q_sh;
          r_q_1   <= r_q[0];
          r_count <= r_count - 4'd1;
          if (w_last) begin
            r_product <= {w_a_sh, w_q_sh};
          end
        end
`else
        C_ST_ADD: begin
          r_a    <= w_a_next;
          r_sign <= w_sign_next;
        end
        C_ST_SHIFT: begin
          r_a     <= w_a_sh;
          r_q     <= w_q_sh;
          r_q_1   <= r_q[0];
          r_count <= r_count - 4'd1;
          if (w_last) begin
            r_product <= {w_a_sh, w_q_sh};
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul_ctrl
// Description : Scoreboard bench for booth_mul_ctrl. A reference model
//               predicts acceptance, timing and the signed product; a
//               monitor compares DUT outputs every cycle. Build with
//               BOOTH_FAST_EN to check the fast variant.
// Revision    : 1.0  initial release
// ============================================================================
module tb_booth_mul_ctrl;

`ifdef BOOTH_FAST_EN
  localparam int C_LAT = 9;
`else
  localparam int C_LAT = 17;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          total;
  int          bad;
  int          rem;          // model: cycles of busy left
  logic [15:0] last_prod;    // model: value product must hold
  logic [15:0] sb_q[$];      // scoreboard of expected products

  booth_mul_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepts start when idle, expects the signed product.
  always @(posedge clk) begin
    if (rst) begin
      rem       = 0;
      last_prod = 16'h0000;
      sb_q.delete();
    end else if (rem == 0) begin
      if (start) begin
        logic signed [15:0] p;
        p = $signed(multiplicand) * $signed(multiplier);
        sb_q.push_back(p);
        rem = C_LAT;
      end
    end else begin
      rem = rem - 1;
    end
  end

  // Monitor: compares busy, done, product each cycle away from the edge.
  always @(negedge clk) begin
    logic [15:0] exp_p;
    chk("busy", {15'd0, busy}, {15'd0, (rem != 0)});
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 16'd1, 16'd0);
      end else begin
        exp_p = sb_q.pop_front();
        chk("product", product, exp_p);
        chk("done_latency", {15'd0, (rem == 1)}, 16'd1);
        last_prod = exp_p;
      end
    end else begin
      if (rem == 1) begin
        chk("missing_done", {15'd0, done}, 16'd1);
        if (sb_q.size() != 0) begin
          last_prod = sb_q.pop_front();
        end
      end
      chk("product_hold", product, last_prod);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (rem != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rem != 0) chk("idle_timeout", 16'd1, 16'd0);
  endtask

  // Issue one start pulse; operands are scrambled right after capture.
  task automatic issue(input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rem   = 0;
    last_prod = 16'h0000;
    rst   = 1'b1;
    start = 1'b0;
    multiplicand = 8'h00;
    multiplier   = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed corner cases.
    issue(8'd7, 8'd3);          wait_idle();
    issue(8'h80, 8'h80);        wait_idle();
    issue(8'h80, 8'h7F);        wait_idle();
    issue(8'h7F, 8'hFF);        wait_idle();
    issue(8'h00, 8'h80);        wait_idle();
    issue(8'hFF, 8'hFF);        wait_idle();

    // Stray start during an operation must be ignored.
    issue(8'd13, 8'hF5);
    repeat (4) @(negedge clk);
    start = 1'b1;
    multiplicand = 8'h55;
    multiplier   = 8'h66;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of an operation, then a fresh multiply.
    issue(8'd100, 8'd100);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(8'd5, 8'hFA);         wait_idle();

    // Start held high: back-to-back operations with changing operands.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3 * 18 + 2; i++) begin
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Random sweep.
    for (int i = 0; i < 60; i++) begin
      issue(8'($urandom), 8'($urandom));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 16'(sb_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
